imem_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the single combinational read port of InstructionMemory.

---
 rtl/imem_fetch_ctrl_if.sv | 47 ++++
 rtl/imem_fetch_ctrl.sv | 104 ++++++++++
 tb/tb_imem_fetch_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// Signal bundle between the fetch controller, the instruction-memory read port and decode.
// The master side is the fetch controller; the slave side is memory plus decode.
interface imem_fetch_ctrl_if #(
   parameter int FIFO_DEPTH = 2
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]   ImemAddress;
   logic [31:0]   ImemInstruction;
   logic          FetchEnable;
   logic          Redirect;
   logic [31:0]   RedirectPC;
   logic          InstrValid;
   logic          InstrReady;
   logic [31:0]   InstrOut;
   logic [31:0]   InstrPC;
   logic [CW-1:0] FifoCount;
   logic          FetchFault;

   modport master (
      output ImemAddress,
      input  ImemInstruction,
      input  FetchEnable,
      input  Redirect,
      input  RedirectPC,
      output InstrValid,
      input  InstrReady,
      output InstrOut,
      output InstrPC,
      output FifoCount,
      output FetchFault
   );

   modport slave (
      input  ImemAddress,
      output ImemInstruction,
      output FetchEnable,
      output Redirect,
      output RedirectPC,
      input  InstrValid,
      output InstrReady,
      input  InstrOut,
      input  InstrPC,
      input  FifoCount,
      input  FetchFault
   );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: walks the fetch PC over a combinational instruction memory, buffers
// {PC, word} pairs in a small prefetch FIFO and hands them to decode via valid/ready.
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter int          MEM_WORDS  = 512
) (
   input logic               Clk,
   input logic               Rst_n,
   imem_fetch_ctrl_if.master fetch_if
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t        fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          fault_q, fault_d;

   logic in_range;
   logic pop;
   logic room;
   logic push;

   assign in_range = {2'b00, fetch_pc_q[31:2]} < 32'(MEM_WORDS);
   assign pop      = (count_q != '0) & fetch_if.InstrReady & ~fetch_if.Redirect;
   assign room     = (count_q < CW'(FIFO_DEPTH)) | pop;
   assign push     = fetch_if.FetchEnable & room & ~fault_q & ~fetch_if.Redirect & in_range;

   // NOTE: every variable gets its hold value first, so no path through this block can infer a latch.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      fetch_pc_d = fetch_pc_q;
      fault_d    = fault_q;

      if (fetch_if.Redirect) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = {fetch_if.RedirectPC[31:2], 2'b00};
         fault_d    = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + PW'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (fetch_if.FetchEnable & room & ~in_range) begin
            fault_d = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         fetch_pc_q <= RESET_PC;
         fault_q    <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         fetch_pc_q <= fetch_pc_d;
         fault_q    <= fault_d;
      end
   end

   // NOTE: the storage is reset on purpose: decode sees InstrOut/InstrPC as zero straight out of reset.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else if (push) begin
         fifo_q[wr_ptr_q] <= '{pc: fetch_pc_q, instr: fetch_if.ImemInstruction};
      end
   end

   assign fetch_if.ImemAddress = fetch_pc_q;
   assign fetch_if.InstrValid  = (count_q != '0);
   assign fetch_if.InstrOut    = fifo_q[rd_ptr_q].instr;
   assign fetch_if.InstrPC     = fifo_q[rd_ptr_q].pc;
   assign fetch_if.FifoCount   = count_q;
   assign fetch_if.FetchFault  = fault_q;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: a reference model fills a scoreboard queue as
// words are fetched, and each word decode accepts is compared against the queue head.
module tb_imem_fetch_ctrl;
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam int          FIFO_DEPTH = 2;
   localparam int          MEM_WORDS  = 512;
   localparam int          CW         = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   logic        Clk;
   logic        Rst_n;
   logic [31:0] key;
   int          passed;
   int          total;

   entry_t      sb[$];
   logic [31:0] m_pc;
   logic        m_fault;

   imem_fetch_ctrl_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

   imem_fetch_ctrl #(
      .RESET_PC  (RESET_PC),
      .FIFO_DEPTH(FIFO_DEPTH),
      .MEM_WORDS (MEM_WORDS)
   ) dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .fetch_if(bus.master)
   );

   // Instruction memory: mem[i] = i*4, optionally scrambled by key.
   assign bus.ImemInstruction = bus.ImemAddress ^ key;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic model_reset();
      sb.delete();
      m_pc    = RESET_PC;
      m_fault = 1'b0;
   endtask

   // Advance one clock (called at a negedge); reports the model pop and the DUT head seen before the edge.
   task automatic tick(output logic popped, output entry_t exp_e, output entry_t got_e);
      logic   room;
      logic   push;
      logic   oor;
      entry_t e;
      popped    = (sb.size() != 0) && bus.InstrReady && !bus.Redirect;
      exp_e     = (sb.size() != 0) ? sb[0] : '0;
      got_e.pc  = bus.InstrPC;
      got_e.instr = bus.InstrOut;
      room = (sb.size() < FIFO_DEPTH) || popped;
      oor  = (m_pc[31:2] >= 30'(MEM_WORDS));
      push = bus.FetchEnable && room && !m_fault && !bus.Redirect && !oor;
      @(posedge Clk);
      if (bus.Redirect) begin
         sb.delete();
         m_pc    = {bus.RedirectPC[31:2], 2'b00};
         m_fault = 1'b0;
      end else begin
         if (popped) void'(sb.pop_front());
         if (push) begin
            e.pc    = m_pc;
            e.instr = m_pc ^ key;
            sb.push_back(e);
            m_pc = m_pc + 32'd4;
         end else if (bus.FetchEnable && room && oor) begin
            m_fault = 1'b1;
         end
      end
      @(negedge Clk);
   endtask

   task automatic apply_reset();
      Rst_n           = 1'b0;
      key             = '0;
      bus.FetchEnable = 1'b0;
      bus.InstrReady  = 1'b0;
      bus.Redirect    = 1'b0;
      bus.RedirectPC  = '0;
      model_reset();
      @(negedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      key             = '0;
      bus.FetchEnable = 1'b0;
      bus.InstrReady  = 1'b0;
      bus.Redirect    = 1'b0;
      bus.RedirectPC  = '0;
      model_reset();
      @(negedge Clk);
      total++; if (bus.InstrValid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.InstrValid); else passed++;
      total++; if (bus.FifoCount !== CW'(0)) $display("FAIL reset_count: got %0d expected 0", bus.FifoCount); else passed++;
      total++; if (bus.InstrOut !== 32'h0) $display("FAIL reset_instr: got %h expected 0", bus.InstrOut); else passed++;
      total++; if (bus.InstrPC !== 32'h0) $display("FAIL reset_pc: got %h expected 0", bus.InstrPC); else passed++;
      total++; if (bus.FetchFault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", bus.FetchFault); else passed++;
      total++; if (bus.ImemAddress !== RESET_PC) $display("FAIL reset_addr: got %h expected %h", bus.ImemAddress, RESET_PC); else passed++;
      @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   task automatic test_stream();
      logic p; entry_t e, g;
      apply_reset();
      bus.FetchEnable = 1'b1;
      bus.InstrReady  = 1'b1;
      tick(p, e, g);
      for (int i = 0; i < 3; i++) begin
         total++; if (bus.FifoCount !== CW'(1)) $display("FAIL stream_count%0d: got %0d expected 1", i, bus.FifoCount); else passed++;
         tick(p, e, g);
         total++;
         if (!p || g !== e || g.pc !== 32'(i * 4) || g.instr !== 32'(i * 4))
            $display("FAIL stream_word%0d: got %h (pop %b) expected %h", i, g, p, {32'(i * 4), 32'(i * 4)});
         else passed++;
      end
   endtask

   task automatic test_backpressure();
      logic p; entry_t e, g;
      int n;
      apply_reset();
      bus.FetchEnable = 1'b1;
      bus.InstrReady  = 1'b0;
      tick(p, e, g);
      for (int i = 0; i < 4; i++) begin
         total++; if (bus.InstrPC !== 32'h0 || bus.InstrOut !== 32'h0 || bus.InstrValid !== 1'b1)
            $display("FAIL stall_head%0d: got pc %h instr %h valid %b expected 0 0 1", i, bus.InstrPC, bus.InstrOut, bus.InstrValid);
         else passed++;
         tick(p, e, g);
      end
      total++; if (bus.FifoCount !== CW'(2)) $display("FAIL stall_count: got %0d expected 2", bus.FifoCount); else passed++;
      total++; if (bus.ImemAddress !== 32'h8) $display("FAIL stall_addr: got %h expected 8", bus.ImemAddress); else passed++;
      bus.InstrReady = 1'b1;
      n = 0;
      for (int i = 0; i < 8 && n < 4; i++) begin
         tick(p, e, g);
         if (p) begin
            total++;
            if (g !== e || g.pc !== 32'(n * 4)) $display("FAIL drain_word%0d: got %h expected pc %h sb %h", n, g, 32'(n * 4), e);
            else passed++;
            n++;
         end
      end
      total++; if (n != 4) $display("FAIL drain_count: got %0d expected 4", n); else passed++;
   endtask

   task automatic test_redirect();
      logic p; entry_t e, g;
      logic found;
      apply_reset();
      bus.FetchEnable = 1'b1;
      bus.InstrReady  = 1'b0;
      tick(p, e, g);
      tick(p, e, g);
      total++; if (bus.FifoCount !== CW'(2)) $display("FAIL redir_full: got %0d expected 2", bus.FifoCount); else passed++;
      bus.Redirect   = 1'b1;
      bus.RedirectPC = 32'h47;
      bus.InstrReady = 1'b1;
      tick(p, e, g);
      bus.Redirect = 1'b0;
      total++; if (bus.FifoCount !== CW'(0) || bus.InstrValid !== 1'b0)
         $display("FAIL redir_flush: got count %0d valid %b expected 0 0", bus.FifoCount, bus.InstrValid);
      else passed++;
      total++; if (bus.ImemAddress !== 32'h44) $display("FAIL redir_addr: got %h expected 44", bus.ImemAddress); else passed++;
      key   = 32'h5A5A_0000;
      found = 1'b0;
      for (int i = 0; i < 5 && !found; i++) begin
         tick(p, e, g);
         if (p) begin
            found = 1'b1;
            total++;
            if (g !== e || g.pc !== 32'h44 || g.instr !== (32'h44 ^ 32'h5A5A_0000))
               $display("FAIL redir_first: got %h expected %h", g, {32'h44, 32'h5A5A_0044});
            else passed++;
         end
      end
      total++; if (!found) $display("FAIL redir_timeout: got no word expected pc 44"); else passed++;
   endtask

   task automatic test_fault();
      logic p; entry_t e, g;
      bus.FetchEnable = 1'b1;
      bus.InstrReady  = 1'b0;
      bus.Redirect    = 1'b1;
      bus.RedirectPC  = 32'h7FC;
      tick(p, e, g);
      bus.Redirect = 1'b0;
      tick(p, e, g);
      tick(p, e, g);
      total++; if (bus.FetchFault !== 1'b1) $display("FAIL fault_set: got %b expected 1", bus.FetchFault); else passed++;
      total++; if (bus.ImemAddress !== 32'h800) $display("FAIL fault_addr: got %h expected 800", bus.ImemAddress); else passed++;
      for (int i = 0; i < 3; i++) tick(p, e, g);
      total++; if (bus.FifoCount !== CW'(1)) $display("FAIL fault_count: got %0d expected 1", bus.FifoCount); else passed++;
      bus.InstrReady = 1'b1;
      tick(p, e, g);
      total++; if (!p || g !== e || g.pc !== 32'h7FC || g.instr !== 32'h5A5A_07FC)
         $display("FAIL fault_last: got %h (pop %b) expected %h", g, p, {32'h7FC, 32'h5A5A_07FC});
      else passed++;
      total++; if (bus.FifoCount !== CW'(0) || bus.FetchFault !== 1'b1)
         $display("FAIL fault_drain: got count %0d fault %b expected 0 1", bus.FifoCount, bus.FetchFault);
      else passed++;
      bus.Redirect   = 1'b1;
      bus.RedirectPC = 32'h0;
      tick(p, e, g);
      bus.Redirect = 1'b0;
      total++; if (bus.FetchFault !== 1'b0 || bus.ImemAddress !== 32'h0)
         $display("FAIL fault_clear: got fault %b addr %h expected 0 0", bus.FetchFault, bus.ImemAddress);
      else passed++;
      tick(p, e, g);
      tick(p, e, g);
      total++; if (!p || g !== e || g.pc !== 32'h0)
         $display("FAIL fault_resume: got %h (pop %b) expected pc 0 sb %h", g, p, e);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic p; entry_t e, g;
      apply_reset();
      key             = 32'h0F0F_0000;
      bus.FetchEnable = 1'b1;
      bus.InstrReady  = 1'b0;
      tick(p, e, g);
      tick(p, e, g);
      bus.InstrReady = 1'b1;
      for (int i = 0; i < 10; i++) begin
         total++; if (bus.FifoCount !== CW'(2)) $display("FAIL b2b_count%0d: got %0d expected 2", i, bus.FifoCount); else passed++;
         tick(p, e, g);
         total++; if (!p || g !== e || g.pc !== 32'(i * 4))
            $display("FAIL b2b_word%0d: got %h (pop %b) expected pc %h sb %h", i, g, p, 32'(i * 4), e);
         else passed++;
      end
   endtask

   task automatic test_async_reset();
      logic p; entry_t e, g;
      apply_reset();
      bus.FetchEnable = 1'b1;
      bus.InstrReady  = 1'b0;
      tick(p, e, g);
      tick(p, e, g);
      total++; if (bus.FifoCount !== CW'(2) || bus.InstrValid !== 1'b1)
         $display("FAIL areset_pre: got count %0d valid %b expected 2 1", bus.FifoCount, bus.InstrValid);
      else passed++;
      #2 Rst_n = 1'b0;
      model_reset();
      #1;
      total++; if (bus.InstrValid !== 1'b0 || bus.FifoCount !== CW'(0))
         $display("FAIL areset_now: got valid %b count %0d expected 0 0", bus.InstrValid, bus.FifoCount);
      else passed++;
      total++; if (bus.ImemAddress !== RESET_PC) $display("FAIL areset_addr: got %h expected %h", bus.ImemAddress, RESET_PC); else passed++;
      @(negedge Clk);
      Rst_n          = 1'b1;
      bus.InstrReady = 1'b1;
      tick(p, e, g);
      tick(p, e, g);
      total++; if (!p || g !== e || g.pc !== RESET_PC)
         $display("FAIL areset_restart: got %h (pop %b) expected pc %h sb %h", g, p, RESET_PC, e);
      else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      Rst_n  = 1'b0;
      key    = '0;
      bus.FetchEnable = 1'b0;
      bus.InstrReady  = 1'b0;
      bus.Redirect    = 1'b0;
      bus.RedirectPC  = '0;
      model_reset();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_fault();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
